// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller with a shadow scoreboard of EX/MEM/WB destinations.
// Build option: define FORWARDING_EN to stall only on load-use; otherwise stall until the producer retires.
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_rd_we_i,
  input  logic        id_mem_re_i,
  input  logic        exe_redirect_i,
  input  logic        exe_mc_start_i,
  input  logic        exe_mc_done_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_exe_stall_o,
  output logic        if_id_flush_o,
  output logic        id_exe_flush_o,
  output logic        exe_mem_flush_o,
  output logic [31:0] stall_cnt_o
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } slot_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam slot_t BUBBLE = '0;

  function automatic logic src_match(input logic re, input logic [4:0] addr, input slot_t s);
    return re && (addr != 5'd0) && s.vld && s.we && (s.rd == addr);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  state_t      state_q, state_d;
  slot_t       ex_p0, mem_p1, wb_p2;
  slot_t       ex_d, mem_d, wb_d;
  slot_t       id_slot;
  logic        hazard;
  logic        run_like;
  logic [31:0] stall_cnt_q;
  logic        unused_wb;

  assign id_slot = '{vld: id_valid_i, rd: id_rd_addr_i, we: id_rd_we_i, is_load: id_mem_re_i};
  assign unused_wb = ^wb_p2;

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = id_valid_i && ex_p0.is_load &&
                  (src_match(id_rs1_re_i, id_rs1_addr_i, ex_p0) ||
                   src_match(id_rs2_re_i, id_rs2_addr_i, ex_p0));
`else
  assign hazard = id_valid_i &&
                  (src_match(id_rs1_re_i, id_rs1_addr_i, ex_p0)  ||
                   src_match(id_rs2_re_i, id_rs2_addr_i, ex_p0)  ||
                   src_match(id_rs1_re_i, id_rs1_addr_i, mem_p1) ||
                   src_match(id_rs2_re_i, id_rs2_addr_i, mem_p1) ||
                   src_match(id_rs1_re_i, id_rs1_addr_i, wb_p2)  ||
                   src_match(id_rs2_re_i, id_rs2_addr_i, wb_p2));
`endif

  // A completing multi-cycle op releases the pipe in the same cycle.
  assign run_like = (state_q == RUN) || exe_mc_done_i;

  always_comb begin
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    id_exe_stall_o  = 1'b0;
    if_id_flush_o   = 1'b0;
    id_exe_flush_o  = 1'b0;
    exe_mem_flush_o = 1'b0;
    state_d         = state_q;
    ex_d            = ex_p0;
    mem_d           = mem_p1;
    wb_d            = wb_p2;

    if (!run_like) begin
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      id_exe_stall_o  = 1'b1;
      exe_mem_flush_o = 1'b1;
      mem_d           = BUBBLE;
      wb_d            = mem_p1;
    end else begin
      mem_d = ex_p0;
      wb_d  = mem_p1;
      if (exe_redirect_i) begin
        if_id_flush_o  = 1'b1;
        id_exe_flush_o = 1'b1;
        ex_d           = BUBBLE;
      end else if (hazard) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_exe_flush_o = 1'b1;
        ex_d           = BUBBLE;
      end else begin
        ex_d = id_valid_i ? id_slot : BUBBLE;
      end
    end

    case (state_q)
      RUN:     if (exe_mc_start_i && !exe_mc_done_i) state_d = MC_BUSY;
      MC_BUSY: if (exe_mc_done_i) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Reset dominates: fetch and ID are flushed, nothing is held.
    if (rst_i) begin
      pc_stall_o      = 1'b0;
      if_id_stall_o   = 1'b0;
      id_exe_stall_o  = 1'b0;
      if_id_flush_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
      exe_mem_flush_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      ex_p0       <= BUBBLE;
      mem_p1      <= BUBBLE;
      wb_p2       <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // EX -> MEM -> WB scoreboard advance
      ex_p0   <= ex_d;
      mem_p1  <= mem_d;
      wb_p2   <= wb_d;
      if (pc_stall_o) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expected values adapt when FORWARDING_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        re1 = 1'b0, re2 = 1'b0, we = 1'b0, ld = 1'b0;
  logic        redirect = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic        pc_stall, if_id_stall, id_exe_stall, if_id_flush, id_exe_flush, exe_mem_flush;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = '0;

  // {pc_stall, if_id_stall, id_exe_stall, if_id_flush, id_exe_flush, exe_mem_flush}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_RST   = 6'b000110;
  localparam logic [5:0] O_REDIR = 6'b000110;
  localparam logic [5:0] O_HAZ   = 6'b110010;
  localparam logic [5:0] O_BUSY  = 6'b111001;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_valid_i      (id_valid),
    .id_rs1_addr_i   (rs1),
    .id_rs2_addr_i   (rs2),
    .id_rs1_re_i     (re1),
    .id_rs2_re_i     (re2),
    .id_rd_addr_i    (rd),
    .id_rd_we_i      (we),
    .id_mem_re_i     (ld),
    .exe_redirect_i  (redirect),
    .exe_mc_start_i  (mc_start),
    .exe_mc_done_i   (mc_done),
    .pc_stall_o      (pc_stall),
    .if_id_stall_o   (if_id_stall),
    .id_exe_stall_o  (id_exe_stall),
    .if_id_flush_o   (if_id_flush),
    .id_exe_flush_o  (id_exe_flush),
    .exe_mem_flush_o (exe_mem_flush),
    .stall_cnt_o     (stall_cnt)
  );

  task automatic id_set(input logic v, input logic [4:0] a1, input logic e1,
                        input logic [4:0] a2, input logic e2,
                        input logic [4:0] d, input logic w, input logic l);
    id_valid = v; rs1 = a1; re1 = e1; rs2 = a2; re2 = e2; rd = d; we = w; ld = l;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {pc_stall, if_id_stall, id_exe_stall, if_id_flush, id_exe_flush, exe_mem_flush};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: outputs got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (stall_cnt === exp) else begin
      errors++;
      $error("FAIL %s: stall_cnt got %0d expected %0d", tag, stall_cnt, exp);
    end
  endtask

  task automatic drain();
    nc(); id_idle(); redirect = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    repeat (3) nc();
  endtask

  initial begin
    #2;
    chk_out("reset_outputs", O_RST);
    chk_cnt("reset_cnt", 32'd0);

    nc(); rst = 1'b0; id_idle(); #2;
    chk_out("idle_after_reset", O_NONE);

`ifdef FORWARDING_EN
    nc(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); #2;   // lw x5
    chk_out("lw_enter", O_NONE);
    nc(); id_set(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0); #2;   // add x6,x5,x1
    chk_out("load_use_stall", O_HAZ);
    nc(); #2;
    chk_out("load_use_release", O_NONE);
    exp_cnt = 32'd1;
    chk_cnt("load_use_cnt", exp_cnt);
`else
    nc(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0); #2;   // addi x5
    chk_out("addi_enter", O_NONE);
    nc(); id_set(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0); #2;   // add x6,x5,x5
    chk_out("raw_stall_ex", O_HAZ);
    nc(); #2;
    chk_out("raw_stall_mem", O_HAZ);
    chk_cnt("raw_cnt1", 32'd1);
    nc(); #2;
    chk_out("raw_stall_wb", O_HAZ);
    chk_cnt("raw_cnt2", 32'd2);
    nc(); #2;
    chk_out("raw_release", O_NONE);
    exp_cnt = 32'd3;
    chk_cnt("raw_cnt3", exp_cnt);
`endif
    drain();

    nc(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd7, 0, 0); #2;   // rd=x7 without write
    chk_out("no_we_enter", O_NONE);
    nc(); id_set(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0); #2;
    chk_out("no_we_no_stall", O_NONE);
    nc(); id_set(1, 5'd8, 0, 5'd8, 0, 5'd9, 1, 0); #2;   // reads disabled
    chk_out("re_off_no_stall", O_NONE);
    drain();

    nc(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1); #2;   // lw x0
    chk_out("lw_x0_enter", O_NONE);
    nc(); id_set(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0); #2;
    chk_out("x0_source", O_NONE);
    drain();

    nc(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); #2;   // lw x5
    chk_out("lw_x5_enter", O_NONE);
    nc(); id_set(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0); redirect = 1'b1; #2;
    chk_out("redirect_over_hazard", O_REDIR);
    nc(); redirect = 1'b0; id_idle(); #2;
    chk_out("after_redirect", O_NONE);
    chk_cnt("redirect_cnt", exp_cnt);
    drain();

    nc(); mc_start = 1'b1; mc_done = 1'b1; #2;
    chk_out("start_done_same", O_NONE);
    nc(); mc_start = 1'b0; mc_done = 1'b0; #2;
    chk_out("start_done_stays_run", O_NONE);

    nc(); mc_start = 1'b1; id_set(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1); #2;   // lw x9 + mc start
    chk_out("mc_start", O_NONE);
    nc(); mc_start = 1'b0; id_idle(); #2;
    chk_out("mc_busy1", O_BUSY);
    nc(); redirect = 1'b1; #2;
    chk_out("mc_busy2_redirect_ignored", O_BUSY);
    nc(); redirect = 1'b0; #2;
    chk_out("mc_busy3", O_BUSY);
    nc(); #2;
    chk_out("mc_busy4", O_BUSY);
    exp_cnt = exp_cnt + 32'd4;
    nc(); mc_done = 1'b1; id_set(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0); #2;   // EX still holds lw x9
    chk_out("mc_done_load_use", O_HAZ);
    chk_cnt("mc_busy_cnt", exp_cnt);
    exp_cnt = exp_cnt + 32'd1;
    nc(); mc_done = 1'b0; #2;
`ifdef FORWARDING_EN
    chk_out("post_mc_release", O_NONE);
`else
    chk_out("post_mc_mem_stall", O_HAZ);
    exp_cnt = exp_cnt + 32'd1;
`endif
    nc(); id_idle(); #2;
    chk_out("post_mc_run", O_NONE);
    chk_cnt("post_mc_cnt", exp_cnt);
    nc(); redirect = 1'b1; #2;
    chk_out("run_redirect", O_REDIR);
    drain();

    nc(); mc_start = 1'b1; id_set(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 1); #2;
    chk_out("mc2_start", O_NONE);
    nc(); mc_start = 1'b0; id_idle(); #2;
    chk_out("mc2_busy", O_BUSY);
    chk_cnt("pre_reset_cnt", exp_cnt);
    #1 rst = 1'b1; #1;
    chk_out("async_reset_outputs", O_RST);
    chk_cnt("async_reset_cnt", 32'd0);
    nc(); rst = 1'b0; id_set(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0); #2;
    chk_out("post_reset_run_empty", O_NONE);
    chk_cnt("post_reset_cnt", 32'd0);
    nc(); id_idle(); #2;
    chk_out("post_reset_idle", O_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
